// File: rtl/spi_master_burst.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | spi_master_burst : burst SPI master for the AD80305 register bus        |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module spi_master_burst #(
  parameter int CLK_DIV   = 126,
  parameter int N_CS      = 2,
  parameter int ADDR_W    = 10,
  parameter int MAX_BYTES = 8
) (
  input  logic              i_fpga_clk_125p,
  input  logic              i_fpga_rst_125p,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_rw,
  input  logic [2:0]        i_cmd_len,
  input  logic [1:0]        i_cmd_cs,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  output logic              o_wr_req,
  input  logic [7:0]        i_wr_data,
  output logic [7:0]        o_rd_data,
  output logic              o_rd_valid,
  output logic              o_done,
  output logic              o_err,
  output logic              o_busy,
  output logic              o_spi_clk,
  output logic              o_spi_di,
  input  logic              i_spi_do,
  output logic [N_CS-1:0]   o_spi_cs_n
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_INSTR = 3'd2,
    S_DATA  = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(8 * MAX_BYTES);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0] C_RISE = CNT_W'(CLK_DIV / 2 - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BIT_W-1:0] bit_q;
  logic             rw_q;
  logic [2:0]       len_q;
  logic [15:0]      sh_q;
  logic [7:0]       stage_q;
  logic [7:0]       rx_q;
  logic             cap_q;
  logic             ready_q, busy_q, wr_req_q, rd_valid_q, done_q, err_q;
  logic             sclk_q, mosi_q;
  logic [7:0]       rd_data_q;
  logic [N_CS-1:0]  cs_n_q;

  logic bit_end, instr_last, data_last, byte_last, more_bytes;

  assign bit_end    = (cnt_q == C_LAST);
  assign instr_last = (bit_q == BIT_W'(15));
  assign data_last  = (bit_q == BIT_W'({len_q, 3'b111}));
  assign byte_last  = (bit_q[2:0] == 3'b111);
  assign more_bytes = (32'(bit_q[BIT_W-1:3]) < 32'(len_q));

  // Transmit shifter holds the instruction first, then each data byte in its top 8 bits.
  always_ff @(posedge i_fpga_clk_125p or posedge i_fpga_rst_125p) begin
    if (i_fpga_rst_125p) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      rw_q       <= 1'b0;
      len_q      <= '0;
      sh_q       <= '0;
      stage_q    <= '0;
      rx_q       <= '0;
      cap_q      <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      wr_req_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rd_data_q  <= '0;
      cs_n_q     <= '1;
    end else begin
      wr_req_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cap_q      <= wr_req_q;
      if (cap_q) stage_q <= i_wr_data;
      if (state_q != S_IDLE) cnt_q <= bit_end ? '0 : cnt_q + CNT_W'(1);
      if (state_q == S_INSTR || state_q == S_DATA) begin
        if (cnt_q == C_RISE) sclk_q <= 1'b1;
        else if (bit_end)    sclk_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (i_cmd_valid) begin
            if (32'(i_cmd_cs) >= N_CS) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              state_q <= S_SETUP;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
              rw_q    <= i_cmd_rw;
              len_q   <= i_cmd_len;
              sh_q    <= {i_cmd_rw, i_cmd_len, 12'(i_cmd_addr)};
              cs_n_q  <= ~(N_CS'(1) << i_cmd_cs);
              cnt_q   <= '0;
              bit_q   <= '0;
            end
          end
        end
        S_SETUP: begin
          if (cnt_q == '0 && rw_q) wr_req_q <= 1'b1;
          if (bit_end) begin
            state_q <= S_INSTR;
            mosi_q  <= sh_q[15];
            sh_q    <= {sh_q[14:0], 1'b0};
          end
        end
        S_INSTR: begin
          if (bit_end) begin
            if (instr_last) begin
              state_q <= S_DATA;
              bit_q   <= '0;
              mosi_q  <= rw_q & stage_q[7];
              sh_q    <= {stage_q[6:0], 9'b0};
            end else begin
              bit_q  <= bit_q + BIT_W'(1);
              mosi_q <= sh_q[15];
              sh_q   <= {sh_q[14:0], 1'b0};
            end
          end
        end
        S_DATA: begin
          // Prefetch the next write byte during the last bit of the current one.
          if (cnt_q == '0 && rw_q && byte_last && more_bytes) wr_req_q <= 1'b1;
          if (cnt_q == C_HALF && !rw_q) begin
            rx_q <= {rx_q[6:0], i_spi_do};
            if (byte_last) begin
              rd_data_q  <= {rx_q[6:0], i_spi_do};
              rd_valid_q <= 1'b1;
            end
          end
          if (bit_end) begin
            if (data_last) begin
              state_q <= S_HOLD;
              mosi_q  <= 1'b0;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
              if (byte_last) begin
                mosi_q <= rw_q & stage_q[7];
                sh_q   <= {stage_q[6:0], 9'b0};
              end else begin
                mosi_q <= rw_q & sh_q[15];
                sh_q   <= {sh_q[14:0], 1'b0};
              end
            end
          end
        end
        S_HOLD: begin
          if (bit_end) begin
            state_q <= S_GAP;
            cs_n_q  <= '1;
          end
        end
        S_GAP: begin
          if (bit_end) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_busy      = busy_q;
  assign o_wr_req    = wr_req_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_spi_clk   = sclk_q;
  assign o_spi_di    = mosi_q;
  assign o_spi_cs_n  = cs_n_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_burst.sv
`default_nettype none
// tb_spi_master_burst : scoreboard bench for spi_master_burst (CLK_DIV=8, N_CS=2).
module tb_spi_master_burst;

  localparam int CLK_DIV = 8;
  localparam int N_CS    = 2;
  localparam int ADDR_W  = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_cmd_valid = 1'b0;
  logic              o_cmd_ready;
  logic              i_cmd_rw = 1'b0;
  logic [2:0]        i_cmd_len = '0;
  logic [1:0]        i_cmd_cs = '0;
  logic [ADDR_W-1:0] i_cmd_addr = '0;
  logic              o_wr_req;
  logic [7:0]        i_wr_data = '0;
  logic [7:0]        o_rd_data;
  logic              o_rd_valid, o_done, o_err, o_busy;
  logic              o_spi_clk, o_spi_di;
  logic              i_spi_do = 1'b0;
  logic [N_CS-1:0]   o_spi_cs_n;

  spi_master_burst #(.CLK_DIV(CLK_DIV), .N_CS(N_CS), .ADDR_W(ADDR_W), .MAX_BYTES(8)) dut (
    .i_fpga_clk_125p(clk), .i_fpga_rst_125p(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_rw(i_cmd_rw), .i_cmd_len(i_cmd_len), .i_cmd_cs(i_cmd_cs), .i_cmd_addr(i_cmd_addr),
    .o_wr_req(o_wr_req), .i_wr_data(i_wr_data),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
    .o_spi_clk(o_spi_clk), .o_spi_di(o_spi_di), .i_spi_do(i_spi_do), .o_spi_cs_n(o_spi_cs_n)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [1:0]  csn;
    logic        rw;
    logic [15:0] instr;
    logic [3:0]  nbytes;
  } frame_t;

  typedef struct packed {
    logic       err;
    logic [3:0] nreq;
  } done_t;

  frame_t     sb_frame[$];
  done_t      sb_done[$];
  logic [7:0] sb_mosi[$];
  logic [7:0] sb_rd[$];
  logic [7:0] wr_fifo[$];
  logic [7:0] miso_src[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   f_rises  = 0;
  int   total_rises = 0;
  int   n_wrreq  = 0;
  logic abort    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [7:0] b);
    wr_fifo.push_back(b);
    sb_mosi.push_back(b);
  endtask

  task automatic push_rd(input logic [7:0] b);
    miso_src.push_back(b);
    sb_rd.push_back(b);
    sb_mosi.push_back(8'h00);
  endtask

  task automatic expect_cmd(input logic rw, input logic [2:0] len, input logic valid_cs,
                            input logic [15:0] instr, input logic [1:0] csn);
    if (valid_cs) begin
      sb_frame.push_back('{csn: csn, rw: rw, instr: instr, nbytes: 4'(len) + 4'd1});
      sb_done.push_back('{err: 1'b0, nreq: rw ? 4'(len) + 4'd1 : 4'd0});
    end else begin
      sb_done.push_back('{err: 1'b1, nreq: 4'd0});
    end
  endtask

  // Returns at #1 after the accepting edge, i.e. inside cycle T+1.
  task automatic drive_cmd(input logic rw, input logic [2:0] len, input logic [1:0] cs,
                           input logic [ADDR_W-1:0] addr, input logic hold);
    @(negedge clk);
    i_cmd_rw = rw; i_cmd_len = len; i_cmd_cs = cs; i_cmd_addr = addr; i_cmd_valid = 1'b1;
    for (int i = 0; i < 5000 && !o_cmd_ready; i++) @(negedge clk);
    check("cmd_accept_timeout", o_cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) begin
      i_cmd_valid = 1'b0;
      i_cmd_rw = ~rw; i_cmd_len = ~len; i_cmd_cs = 2'd3; i_cmd_addr = ~addr;
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (sb_done.size() == 0 && o_cmd_ready && !o_busy) break;
    end
    check("idle_timeout", (sb_done.size() == 0) && o_cmd_ready, 1'b1);
  endtask

  // SPI slave + frame monitor
  initial begin
    logic [N_CS-1:0] prev_cs;
    logic            prev_sclk;
    logic            bits[$];
    logic [7:0]      mb[$];
    logic [N_CS-1:0] frame_csn;
    logic [15:0]     instr;
    logic [7:0]      byt, tmp;
    frame_t          f;
    int              r;
    prev_cs = '1;
    prev_sclk = 1'b0;
    frame_csn = '1;
    forever begin
      @(negedge clk);
      if (prev_cs == '1 && o_spi_cs_n != '1) begin
        f_rises = 0;
        bits.delete();
        mb.delete();
        frame_csn = o_spi_cs_n;
        i_spi_do = 1'b0;
        if (sb_frame.size() > 0 && !sb_frame[0].rw)
          for (int k = 0; k < int'(sb_frame[0].nbytes); k++)
            if (miso_src.size() > 0) mb.push_back(miso_src.pop_front());
      end
      if (o_spi_clk && !prev_sclk) begin
        f_rises++;
        total_rises++;
        bits.push_back(o_spi_di);
      end
      if (!o_spi_clk && prev_sclk) begin
        r = f_rises;
        i_spi_do = 1'b0;
        if (r >= 16 && (r - 16) / 8 < mb.size()) begin
          tmp = mb[(r - 16) / 8];
          i_spi_do = tmp[7 - ((r - 16) % 8)];
        end
      end
      if (prev_cs != '1 && o_spi_cs_n == '1 && !abort) begin
        if (sb_frame.size() == 0) begin
          check("unexpected_frame", 1'b1, 1'b0);
        end else begin
          f = sb_frame.pop_front();
          check("frame_cs_n", 32'(frame_csn), 32'(f.csn));
          check("frame_sclk_rises", f_rises, 16 + 8 * int'(f.nbytes));
          if (bits.size() >= 16 + 8 * int'(f.nbytes)) begin
            instr = '0;
            for (int k = 0; k < 16; k++) instr = {instr[14:0], bits[k]};
            check("frame_instr", 32'(instr), 32'(f.instr));
            for (int b = 0; b < int'(f.nbytes); b++) begin
              byt = '0;
              for (int k = 0; k < 8; k++) byt = {byt[6:0], bits[16 + 8 * b + k]};
              if (sb_mosi.size() == 0) check("mosi_sb_empty", 1'b1, 1'b0);
              else check("frame_mosi_byte", 32'(byt), 32'(sb_mosi.pop_front()));
            end
          end
        end
      end
      prev_cs = o_spi_cs_n;
      prev_sclk = o_spi_clk;
    end
  end

  // Write-FIFO model and done/read-data monitor
  initial begin
    done_t d;
    forever begin
      @(negedge clk);
      if (o_wr_req) begin
        n_wrreq++;
        if (wr_fifo.size() == 0) check("wr_fifo_underflow", 1'b1, 1'b0);
        else i_wr_data = wr_fifo.pop_front();
      end
      if (o_rd_valid) begin
        if (sb_rd.size() == 0) check("unexpected_rd_valid", 1'b1, 1'b0);
        else check("rd_data", 32'(o_rd_data), 32'(sb_rd.pop_front()));
      end
      if (o_err && !o_done) check("err_without_done", 1'b1, 1'b0);
      if (o_done) begin
        if (sb_done.size() == 0) begin
          check("unexpected_done", 1'b1, 1'b0);
        end else begin
          d = sb_done.pop_front();
          check("done_err", o_err, d.err);
          check("done_wr_req_count", n_wrreq, 32'(d.nreq));
          check("done_cs_n_high", 32'(o_spi_cs_n), 32'h3);
        end
        n_wrreq = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad, gap, dones;
    logic seen_high, accepted;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(o_spi_cs_n), 32'h3);
    check("rst_sclk", o_spi_clk, 1'b0);
    check("rst_mosi", o_spi_di, 1'b0);
    check("rst_rd_data", 32'(o_rd_data), 32'h0);
    check("rst_pulses", {o_wr_req, o_rd_valid, o_done, o_err, o_busy}, 5'b0);
    check("rst_ready", o_cmd_ready, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single-byte write, cs0
    push_wr(8'hA5);
    expect_cmd(1'b1, 3'd0, 1'b1, 16'h8155, 2'b10);
    drive_cmd(1'b1, 3'd0, 2'd0, 10'h155, 1'b0);
    wait_idle();

    // 2: four-byte read, cs1
    push_rd(8'h12); push_rd(8'h34); push_rd(8'h56); push_rd(8'h78);
    expect_cmd(1'b0, 3'd3, 1'b1, 16'h33FF, 2'b01);
    drive_cmd(1'b0, 3'd3, 2'd1, 10'h3FF, 1'b0);
    wait_idle();

    // 3: eight-byte write
    for (int k = 0; k < 8; k++) push_wr(8'(k));
    expect_cmd(1'b1, 3'd7, 1'b1, 16'hF0A5, 2'b01);
    drive_cmd(1'b1, 3'd7, 2'd1, 10'h0A5, 1'b0);
    wait_idle();

    // 4: invalid chip selects
    bad = total_rises;
    expect_cmd(1'b1, 3'd2, 1'b0, 16'h0, 2'b11);
    drive_cmd(1'b1, 3'd2, 2'd2, 10'h011, 1'b0);
    check("inv_err_T1", o_err, 1'b1);
    check("inv_done_T1", o_done, 1'b1);
    check("inv_ready_T1", o_cmd_ready, 1'b1);
    expect_cmd(1'b0, 3'd0, 1'b0, 16'h0, 2'b11);
    drive_cmd(1'b0, 3'd0, 2'd3, 10'h022, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_spi_cs_n != 2'b11 || o_spi_clk || !o_cmd_ready) bad = -1;
    end
    check("inv_no_bus_activity", bad == total_rises, 1'b1);
    wait_idle();

    // 5: reset during data bit 3 of a read
    push_rd(8'hAA); push_rd(8'h55);
    expect_cmd(1'b0, 3'd1, 1'b1, 16'h1100, 2'b10);
    f_rises = 0;
    drive_cmd(1'b0, 3'd1, 2'd0, 10'h100, 1'b0);
    for (int i = 0; i < 3000 && f_rises < 20; i++) @(negedge clk);
    check("abort_reach_data_bit3", f_rises, 20);
    abort = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(o_spi_cs_n), 32'h3);
    check("abort_sclk", o_spi_clk, 1'b0);
    check("abort_busy", o_busy, 1'b0);
    check("abort_ready", o_cmd_ready, 1'b1);
    sb_frame.delete(); sb_done.delete(); sb_mosi.delete(); sb_rd.delete(); miso_src.delete();
    n_wrreq = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_done) dones++;
    end
    check("abort_no_done", dones, 0);
    abort = 1'b0;
    push_wr(8'h3C);
    expect_cmd(1'b1, 3'd0, 1'b1, 16'h80F0, 2'b01);
    drive_cmd(1'b1, 3'd0, 2'd1, 10'h0F0, 1'b0);
    wait_idle();

    // 6: valid held across two commands
    push_wr(8'h11); push_wr(8'h22);
    expect_cmd(1'b1, 3'd1, 1'b1, 16'h9001, 2'b10);
    push_rd(8'hC3);
    expect_cmd(1'b0, 3'd0, 1'b1, 16'h02AA, 2'b01);
    drive_cmd(1'b1, 3'd1, 2'd0, 10'h001, 1'b1);
    i_cmd_rw = 1'b0; i_cmd_len = 3'd0; i_cmd_cs = 2'd1; i_cmd_addr = 10'h2AA;
    seen_high = 1'b0; accepted = 1'b0; gap = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (o_spi_cs_n == 2'b11) begin
        seen_high = 1'b1;
        gap++;
      end else if (seen_high) begin
        break;
      end
      if (o_cmd_ready && !accepted) begin
        check("second_accept_on_done", o_done, 1'b1);
        accepted = 1'b1;
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
      end
    end
    check("second_accepted", accepted, 1'b1);
    check("cs_high_gap_ge_8", gap >= CLK_DIV, 1'b1);
    wait_idle();

    check("leftover_frames", sb_frame.size(), 0);
    check("leftover_mosi", sb_mosi.size(), 0);
    check("leftover_rd", sb_rd.size(), 0);
    check("leftover_wr_fifo", wr_fifo.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
